pipelined_alu: RTL and testbench

Parametrised successor to the team's 4-op registered ALU. Adds a valid/ready handshake on input and output, eight opcodes including shifts and an iterative multiplier, and status flags. The datapath sits between an operand issue stage and a writeback stage.
- Single-cycle ops sustain one result per cycle under no backpressure.
- MUL is multi-cycle and blocks issue while it runs.

---
 rtl/pipelined_alu.sv | 196 +++++++++++++++++++
 tb/tb_pipelined_alu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_alu
// Purpose  : Valid/ready ALU with 8 opcodes, status flags and an optional
//            iterative shift-add multiplier (enabled by define ALU_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             flag_negative,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SHL = 3'd5;
    localparam logic [2:0] c_OP_SRA = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_negative;

    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_overflow;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;

    // Reset term keeps the producer stalled for as long as reset is held.
    assign in_ready = reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_sum   = {1'b0, operandA} + {1'b0, operandB};
    assign w_diff  = {1'b0, operandA} - {1'b0, operandB};
    assign w_shamt = operandB[SHW-1:0];

    always_comb begin
        w_res      = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_res      = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res      = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != operandA[WIDTH-1]);
            end
            c_OP_AND: w_res = operandA & operandB;
            c_OP_OR:  w_res = operandA | operandB;
            c_OP_XOR: w_res = operandA ^ operandB;
            c_OP_SHL: w_res = operandA << w_shamt;
            c_OP_SRA: w_res = WIDTH'($signed(operandA) >>> w_shamt);
            default:  w_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_count;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_mul_done;

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole product right, consuming one multiplier bit.
    assign w_upper     = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                                   : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    assign w_prod_next = {w_upper, r_prod[WIDTH-1:1]};
    assign w_mul_done  = (r_state == S_MUL) && (r_count == CW'(1));
    assign busy        = (r_state == S_MUL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_count <= '0;
        end else if (r_state == S_MUL) begin
            r_prod  <= w_prod_next;
            r_count <= r_count - CW'(1);
        end else if (w_accept && opcode == c_OP_MUL) begin
            r_prod  <= {{WIDTH{1'b0}}, operandB};
            r_mcand <= operandA;
            r_count <= CW'(WIDTH);
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
`ifdef ALU_MUL_EN
            S_IDLE:  if (w_accept && opcode == c_OP_MUL) w_next_state = S_MUL;
            S_MUL:   if (w_mul_done) w_next_state = S_IDLE;
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_negative  <= 1'b0;
`ifdef ALU_MUL_EN
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_prod_next[WIDTH-1:0];
            r_result_hi <= w_prod_next[2*WIDTH-1:WIDTH];
            r_zero      <= (w_prod_next == '0);
            r_carry     <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
            r_overflow  <= 1'b0;
            r_negative  <= w_prod_next[WIDTH-1];
        end else if (w_accept && opcode == c_OP_MUL) begin
            r_out_valid <= 1'b0;
`endif
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_result_hi <= '0;
            r_zero      <= (w_res == '0);
            r_carry     <= w_carry;
            r_overflow  <= w_overflow;
            r_negative  <= w_res[WIDTH-1];
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign result_hi     = r_result_hi;
    assign flag_zero     = r_zero;
    assign flag_carry    = r_carry;
    assign flag_overflow = r_overflow;
    assign flag_negative = r_negative;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu.sv
`default_nettype none
// Scoreboard bench for pipelined_alu (WIDTH=8); MUL checks follow ALU_MUL_EN.
module tb_pipelined_alu;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       z;
        logic       c;
        logic       v;
        logic       n;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] opcode = 3'd0;
    logic [7:0] operandA = 8'd0;
    logic [7:0] operandB = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       flag_zero, flag_carry, flag_overflow, flag_negative, busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operandA(operandA), .operandB(operandB),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_overflow(flag_overflow), .flag_negative(flag_negative),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
            end else begin
                exp_t e;
                exp_t a;
                e = sb.pop_front();
                a = '{res: result, hi: result_hi, z: flag_zero, c: flag_carry,
                      v: flag_overflow, n: flag_negative};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL output: got res=%h hi=%h zcvn=%b%b%b%b expected res=%h hi=%h zcvn=%b%b%b%b",
                             a.res, a.hi, a.z, a.c, a.v, a.n, e.res, e.hi, e.z, e.c, e.v, e.n);
                end
            end
        end
    end

    // Presents one op and waits (bounded) for acceptance; optionally records the expectation.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input bit push);
        in_valid = 1'b1;
        opcode   = op;
        operandA = a;
        operandB = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h,
                                input logic z, input logic c, input logic v, input logic n);
        mk = '{res: r, hi: h, z: z, c: c, v: v, n: n};
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_outputs", {8'd0, result, result_hi, out_valid, flag_zero, flag_carry,
                            flag_overflow, flag_negative, busy, 2'b00}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Single-cycle ops, back-to-back under no backpressure
        send(3'd0, 8'hC8, 8'h64, mk(8'h2C, 8'h00, 0, 1, 0, 0), 1);
        send(3'd0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 0, 1, 1), 1);
        send(3'd1, 8'h05, 8'h07, mk(8'hFE, 8'h00, 0, 1, 0, 1), 1);
        send(3'd6, 8'h90, 8'h0B, mk(8'hF2, 8'h00, 0, 0, 0, 1), 1);
        send(3'd5, 8'h81, 8'h01, mk(8'h02, 8'h00, 0, 0, 0, 0), 1);
        send(3'd2, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 0), 1);
        send(3'd3, 8'h0F, 8'h30, mk(8'h3F, 8'h00, 0, 0, 0, 0), 1);
        send(3'd4, 8'hAA, 8'hAA, mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
        send(3'd1, 8'h80, 8'h01, mk(8'h7F, 8'h00, 0, 0, 1, 0), 1);
        send(3'd0, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1, 1, 0, 0), 1);
        chk("latency1_valid", {31'd0, out_valid}, 32'd1);
        chk("latency1_result", {24'd0, result}, 32'h00);
        send(3'd5, 8'h01, 8'h0F, mk(8'h80, 8'h00, 0, 0, 0, 1), 1);

`ifdef ALU_MUL_EN
        send(3'd7, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 1, 0, 0), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy", {29'd0, busy, in_ready, out_valid}, 32'b100);
        end
        @(negedge clk);
        chk("mul_done", {29'd0, busy, in_ready, out_valid}, 32'b011);
        @(posedge clk); #1;
        send(3'd7, 8'h0D, 8'h0B, mk(8'h8F, 8'h00, 0, 0, 0, 1), 1);
        send(3'd7, 8'h00, 8'h5A, mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
`else
        send(3'd7, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
        chk("op7_busy", {31'd0, busy}, 32'd0);
`endif

        // Backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd0, 8'h01, 8'h01, mk(8'h02, 8'h00, 0, 0, 0, 0), 1);
        in_valid = 1'b1; opcode = 3'd4; operandA = 8'h55; operandB = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {22'd0, result, out_valid, in_ready}, {22'd0, 8'h02, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd4, 8'h55, 8'h0F, mk(8'h5A, 8'h00, 0, 0, 0, 0), 1);
        chk("bp_xor_next", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h5A});

        // Reset mid-operation: nothing in flight may ever be presented
        @(posedge clk); #1;
`ifdef ALU_MUL_EN
        send(3'd7, 8'h0F, 8'h03, mk(8'h2D, 8'h00, 0, 0, 0, 0), 0);
`else
        out_ready = 1'b0;
        send(3'd0, 8'h0F, 8'h03, mk(8'h12, 8'h00, 0, 0, 0, 0), 0);
`endif
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst_outputs", {8'd0, result, result_hi, out_valid, flag_zero, flag_carry,
                               flag_overflow, flag_negative, busy, in_ready, 1'b0}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_release", {30'd0, in_ready, out_valid}, 32'b10);
        repeat (12) begin
            @(negedge clk);
            chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
